// File: rtl/ct_had_mbkpt_chan_pkg.sv
// Shared encodings for the HAD multi-breakpoint channels: modes, privilege filters,
// channel states and the configuration-word field offsets.
package ct_had_mbkpt_chan_pkg;

   localparam int WD_MODE_LSB  = 32;
   localparam int WD_FLT_LSB   = 36;
   localparam int WD_CHAIN_BIT = 40;

   typedef enum logic [2:0] {
      MODE_OFF  = 3'd0,
      MODE_INST = 3'd1,
      MODE_CHGF = 3'd2,
      MODE_DATA = 3'd3,
      MODE_ST   = 3'd4,
      MODE_LD   = 3'd5
   } mbkpt_mode_e;

   typedef enum logic [1:0] {
      FLT_ANY   = 2'd0,
      FLT_USER  = 2'd1,
      FLT_PRIV  = 2'd2,
      FLT_NEVER = 2'd3
   } mbkpt_flt_e;

   typedef enum logic [2:0] {
      ST_OFF   = 3'd0,
      ST_COUNT = 3'd1,
      ST_ARMED = 3'd2,
      ST_PEND  = 3'd3,
      ST_FIRED = 3'd4
   } mbkpt_st_e;

   // One-hot hit-source selection; all-zero means the channel is off.
   typedef struct packed {
      logic inst;
      logic chgf;
      logic data;
      logic st;
      logic ld;
   } mode_sel_t;

   function automatic mode_sel_t decode_mode(logic [2:0] mode);
      mode_sel_t s;
      s = '0;
      case (mode)
         MODE_INST: s.inst = 1'b1;
         MODE_CHGF: s.chgf = 1'b1;
         MODE_DATA: s.data = 1'b1;
         MODE_ST:   s.st   = 1'b1;
         MODE_LD:   s.ld   = 1'b1;
         default:   s      = '0;
      endcase
      return s;
   endfunction

   // Returns {allow_priv, allow_user}.
   function automatic logic [1:0] decode_flt(logic [1:0] flt);
      logic [1:0] a;
      case (flt)
         FLT_ANY:  a = 2'b11;
         FLT_USER: a = 2'b01;
         FLT_PRIV: a = 2'b10;
         default:  a = 2'b00;
      endcase
      return a;
   endfunction

endpackage

// File: rtl/ct_had_mbkpt_chan_slot.sv
// One breakpoint channel: match counter plus OFF/COUNT/ARMED/PEND/FIRED sequencing.
module ct_had_mbkpt_slot #(
   parameter int CNT_W = 8
) (
   input  logic             cpuclk,
   input  logic             cpurst,
   input  logic             wr_i,
   input  logic [CNT_W-1:0] wr_cnt_i,
   input  logic [2:0]       wr_mode_i,
   input  logic [1:0]       wr_flt_i,
   input  logic             user_i,
   input  logic             inst_hit_i,
   input  logic             data_hit_i,
   input  logic             data_st_i,
   input  logic             chgflow_i,
   input  logic             qual_i,
   input  logic             arm_ok_i,
   input  logic             split_i,
   input  logic             inst_vld_i,
   input  logic             flush_i,
   input  logic             dbgon_i,
   input  logic             ack_i,
   output logic             fired_o,
   output logic             is_data_o,
   output logic [CNT_W-1:0] cnt_o
);
   import ct_had_mbkpt_chan_pkg::*;

   mbkpt_st_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   mode_sel_t        sel_q, sel_d, wr_sel;
   logic [1:0]       allow_q, allow_d;
   logic             fired_q;
   logic             hit_sel, flt_pass, q_hit;

   // Mode and filter are decoded at write time so the hit path only sees flops.
   assign wr_sel   = decode_mode(wr_mode_i);
   assign hit_sel  = (sel_q.inst & inst_hit_i)
                   | (sel_q.chgf & inst_hit_i & chgflow_i)
                   | (sel_q.data & data_hit_i)
                   | (sel_q.st   & data_hit_i & data_st_i)
                   | (sel_q.ld   & data_hit_i & ~data_st_i);
   assign flt_pass = user_i ? allow_q[0] : allow_q[1];
   assign q_hit    = hit_sel & flt_pass & qual_i & arm_ok_i;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      allow_d = allow_q;
      if (wr_i) begin
         sel_d   = wr_sel;
         allow_d = decode_flt(wr_flt_i);
         cnt_d   = wr_cnt_i;
         if (wr_sel == '0)          state_d = ST_OFF;
         else if (wr_cnt_i == '0)   state_d = ST_ARMED;
         else                       state_d = ST_COUNT;
      end else begin
         case (state_q)
            ST_COUNT: begin
               if (q_hit && !split_i && cnt_q != '0) begin
                  cnt_d = cnt_q - CNT_W'(1);
                  if (cnt_q == CNT_W'(1)) state_d = ST_ARMED;
               end
            end
            ST_ARMED: begin
               if (q_hit && !split_i)                state_d = ST_FIRED;
               else if (q_hit && split_i && is_data_o) state_d = ST_PEND;
            end
            ST_PEND: begin
               if (flush_i || dbgon_i)               state_d = ST_ARMED;
               else if (inst_vld_i && !split_i)      state_d = ST_FIRED;
            end
            ST_FIRED: begin
               if (ack_i || flush_i) begin
                  state_d = ST_ARMED;
                  cnt_d   = '0;
               end
            end
            default: state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge cpuclk or posedge cpurst) begin
      if (cpurst) begin
         state_q <= ST_OFF;
         cnt_q   <= '0;
         sel_q   <= '0;
         allow_q <= '0;
         fired_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         allow_q <= allow_d;
         fired_q <= (state_d == ST_FIRED);
      end
   end

   assign fired_o   = fired_q;
   assign is_data_o = sel_q.data | sel_q.st | sel_q.ld;
   assign cnt_o     = cnt_q;

endmodule

// File: rtl/ct_had_mbkpt_chan.sv
// HAD multi-breakpoint channel bank: CHN slots, request merge and lowest-index encoder.
// Define HAD_MBKPT_CHAIN_EN to let channel i>0 wait for channel i-1 to fire (chain bit 40).
module ct_had_mbkpt_chan #(
   parameter  int CHN   = 4,
   parameter  int CNT_W = 8,
   localparam int ID_W  = (CHN > 1) ? $clog2(CHN) : 1
) (
   input  logic                 cpuclk,
   input  logic                 cpurst,
   input  logic                 ctrl_bkpt_en,
   input  logic [1:0]           cp0_yy_priv_mode,
   input  logic                 rtu_had_inst_bkpt_inst_vld,
   input  logic [CHN-1:0]       rtu_had_inst_hit,
   input  logic [CHN-1:0]       rtu_had_data_hit,
   input  logic                 rtu_had_bkpt_data_st,
   input  logic                 rtu_had_xx_mbkpt_chgflow,
   input  logic                 rtu_had_xx_split_inst,
   input  logic                 rtu_yy_xx_retire0_normal,
   input  logic                 rtu_yy_xx_dbgon,
   input  logic                 rtu_yy_xx_flush,
   input  logic                 x_sm_xx_update_dr_en,
   input  logic [CHN-1:0]       ir_xx_mbc_reg_sel,
   input  logic [63:0]          ir_xx_wdata,
   input  logic                 ctrl_bkpt_ack,
   output logic                 bkpt_ctrl_inst_req,
   output logic                 bkpt_ctrl_data_req,
   output logic [CHN-1:0]       bkpt_ctrl_req_chn,
   output logic [ID_W-1:0]      bkpt_ctrl_chn_id,
   output logic [CHN*CNT_W-1:0] bkpt_regs_mbc
);
   import ct_had_mbkpt_chan_pkg::*;

   logic [CHN-1:0]   wr, fired, is_data, arm_ok;
   logic [CNT_W-1:0] wr_cnt;
   logic [2:0]       wr_mode;
   logic [1:0]       wr_flt;
   logic             qual, user, unused_wdata;

   assign qual    = rtu_had_inst_bkpt_inst_vld & rtu_yy_xx_retire0_normal
                  & ctrl_bkpt_en & ~rtu_yy_xx_dbgon;
   assign user    = (cp0_yy_priv_mode == 2'b00);
   assign wr      = {CHN{x_sm_xx_update_dr_en}} & ir_xx_mbc_reg_sel;
   assign wr_cnt  = ir_xx_wdata[CNT_W-1:0];
   assign wr_mode = ir_xx_wdata[WD_MODE_LSB +: 3];
   assign wr_flt  = ir_xx_wdata[WD_FLT_LSB +: 2];
   assign unused_wdata = ^ir_xx_wdata;

`ifdef HAD_MBKPT_CHAIN_EN
   logic [CHN-1:0] chain_q, chain_d, fsince_q, fsince_d;
   logic           unused_chain;

   // fsince tracks "fired since last written"; a write to the channel clears it.
   always_comb begin
      chain_d  = chain_q;
      fsince_d = fsince_q | fired;
      for (int i = 0; i < CHN; i++) begin
         if (wr[i]) begin
            chain_d[i]  = ir_xx_wdata[WD_CHAIN_BIT];
            fsince_d[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge cpuclk or posedge cpurst) begin
      if (cpurst) begin
         chain_q  <= '0;
         fsince_q <= '0;
      end else begin
         chain_q  <= chain_d;
         fsince_q <= fsince_d;
      end
   end

   always_comb begin
      arm_ok    = '1;
      for (int i = 1; i < CHN; i++)
         arm_ok[i] = ~chain_q[i] | fsince_q[i-1] | fired[i-1];
   end

   assign unused_chain = chain_q[0] ^ fsince_q[CHN-1];
`else
   assign arm_ok = '1;
`endif

   for (genvar g = 0; g < CHN; g++) begin : g_slot
      ct_had_mbkpt_slot #(.CNT_W(CNT_W)) u_slot (
         .cpuclk     (cpuclk),
         .cpurst     (cpurst),
         .wr_i       (wr[g]),
         .wr_cnt_i   (wr_cnt),
         .wr_mode_i  (wr_mode),
         .wr_flt_i   (wr_flt),
         .user_i     (user),
         .inst_hit_i (rtu_had_inst_hit[g]),
         .data_hit_i (rtu_had_data_hit[g]),
         .data_st_i  (rtu_had_bkpt_data_st),
         .chgflow_i  (rtu_had_xx_mbkpt_chgflow),
         .qual_i     (qual),
         .arm_ok_i   (arm_ok[g]),
         .split_i    (rtu_had_xx_split_inst),
         .inst_vld_i (rtu_had_inst_bkpt_inst_vld),
         .flush_i    (rtu_yy_xx_flush),
         .dbgon_i    (rtu_yy_xx_dbgon),
         .ack_i      (ctrl_bkpt_ack),
         .fired_o    (fired[g]),
         .is_data_o  (is_data[g]),
         .cnt_o      (bkpt_regs_mbc[g*CNT_W +: CNT_W])
      );
   end

   assign bkpt_ctrl_req_chn  = fired;
   assign bkpt_ctrl_inst_req = |(fired & ~is_data);
   assign bkpt_ctrl_data_req = |(fired & is_data);

   always_comb begin
      bkpt_ctrl_chn_id = '0;
      for (int i = CHN - 1; i >= 0; i--)
         if (fired[i]) bkpt_ctrl_chn_id = ID_W'(i);
   end

endmodule

// File: tb/tb_ct_had_mbkpt_chan.sv
// Bench for ct_had_mbkpt_chan: directed scenarios plus random traffic against a
// cycle-level reference model, with a scoreboard monitor comparing every cycle.
module tb_ct_had_mbkpt_chan;
   localparam int CHN   = 4;
   localparam int CNT_W = 8;
   localparam int ID_W  = 2;
   localparam int P_OFF = 0, P_CNT = 1, P_ARM = 2, P_PEND = 3, P_FIRE = 4;

   logic                 cpuclk = 1'b0;
   logic                 cpurst = 1'b1;
   logic                 ctrl_bkpt_en;
   logic [1:0]           cp0_yy_priv_mode;
   logic                 rtu_had_inst_bkpt_inst_vld;
   logic [CHN-1:0]       rtu_had_inst_hit, rtu_had_data_hit;
   logic                 rtu_had_bkpt_data_st, rtu_had_xx_mbkpt_chgflow, rtu_had_xx_split_inst;
   logic                 rtu_yy_xx_retire0_normal, rtu_yy_xx_dbgon, rtu_yy_xx_flush;
   logic                 x_sm_xx_update_dr_en;
   logic [CHN-1:0]       ir_xx_mbc_reg_sel;
   logic [63:0]          ir_xx_wdata;
   logic                 ctrl_bkpt_ack;
   logic                 bkpt_ctrl_inst_req, bkpt_ctrl_data_req;
   logic [CHN-1:0]       bkpt_ctrl_req_chn;
   logic [ID_W-1:0]      bkpt_ctrl_chn_id;
   logic [CHN*CNT_W-1:0] bkpt_regs_mbc;

   ct_had_mbkpt_chan #(.CHN(CHN), .CNT_W(CNT_W)) dut (
      .cpuclk(cpuclk), .cpurst(cpurst), .ctrl_bkpt_en(ctrl_bkpt_en),
      .cp0_yy_priv_mode(cp0_yy_priv_mode),
      .rtu_had_inst_bkpt_inst_vld(rtu_had_inst_bkpt_inst_vld),
      .rtu_had_inst_hit(rtu_had_inst_hit), .rtu_had_data_hit(rtu_had_data_hit),
      .rtu_had_bkpt_data_st(rtu_had_bkpt_data_st),
      .rtu_had_xx_mbkpt_chgflow(rtu_had_xx_mbkpt_chgflow),
      .rtu_had_xx_split_inst(rtu_had_xx_split_inst),
      .rtu_yy_xx_retire0_normal(rtu_yy_xx_retire0_normal),
      .rtu_yy_xx_dbgon(rtu_yy_xx_dbgon), .rtu_yy_xx_flush(rtu_yy_xx_flush),
      .x_sm_xx_update_dr_en(x_sm_xx_update_dr_en), .ir_xx_mbc_reg_sel(ir_xx_mbc_reg_sel),
      .ir_xx_wdata(ir_xx_wdata), .ctrl_bkpt_ack(ctrl_bkpt_ack),
      .bkpt_ctrl_inst_req(bkpt_ctrl_inst_req), .bkpt_ctrl_data_req(bkpt_ctrl_data_req),
      .bkpt_ctrl_req_chn(bkpt_ctrl_req_chn), .bkpt_ctrl_chn_id(bkpt_ctrl_chn_id),
      .bkpt_regs_mbc(bkpt_regs_mbc)
   );

   always #5 cpuclk = ~cpuclk;

   typedef struct packed {
      logic                 ireq;
      logic                 dreq;
      logic [CHN-1:0]       chn;
      logic [ID_W-1:0]      id;
      logic [CHN*CNT_W-1:0] mbc;
   } obs_t;

   obs_t exp_q[$];
   obs_t mon_exp, mon_act;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   // Reference model: per-channel phase, configuration and counter.
   int m_ph[CHN], m_mode[CHN], m_flt[CHN], m_cnt[CHN];
   bit m_chain[CHN], m_fs[CHN];

   function automatic bit is_data_mode(int md);
      return (md >= 3) && (md <= 5);
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < CHN; i++) begin
         m_ph[i] = P_OFF; m_mode[i] = 0; m_flt[i] = 0; m_cnt[i] = 0;
         m_chain[i] = 1'b0; m_fs[i] = 1'b0;
      end
   endfunction

   function automatic bit model_q(int i);
      bit sel, pass, q;
      case (m_mode[i])
         1: sel = rtu_had_inst_hit[i];
         2: sel = rtu_had_inst_hit[i] && rtu_had_xx_mbkpt_chgflow;
         3: sel = rtu_had_data_hit[i];
         4: sel = rtu_had_data_hit[i] && rtu_had_bkpt_data_st;
         5: sel = rtu_had_data_hit[i] && !rtu_had_bkpt_data_st;
         default: sel = 1'b0;
      endcase
      case (m_flt[i])
         0: pass = 1'b1;
         1: pass = (cp0_yy_priv_mode == 2'b00);
         2: pass = (cp0_yy_priv_mode != 2'b00);
         default: pass = 1'b0;
      endcase
      q = sel && pass && rtu_had_inst_bkpt_inst_vld && rtu_yy_xx_retire0_normal
          && ctrl_bkpt_en && !rtu_yy_xx_dbgon;
`ifdef HAD_MBKPT_CHAIN_EN
      if (i > 0 && m_chain[i] && !(m_fs[i-1] || m_ph[i-1] == P_FIRE)) q = 1'b0;
`endif
      return q;
   endfunction

   function automatic obs_t model_next();
      int nph[CHN], nmode[CHN], nflt[CHN], ncnt[CHN];
      bit nchain[CHN], nfs[CHN];
      bit q, spl;
      obs_t o;
      spl = rtu_had_xx_split_inst;
      for (int i = 0; i < CHN; i++) begin
         q = model_q(i);
         nph[i] = m_ph[i]; nmode[i] = m_mode[i]; nflt[i] = m_flt[i]; ncnt[i] = m_cnt[i];
         nchain[i] = m_chain[i]; nfs[i] = m_fs[i] || (m_ph[i] == P_FIRE);
         if (x_sm_xx_update_dr_en && ir_xx_mbc_reg_sel[i]) begin
            nmode[i]  = int'(ir_xx_wdata[34:32]);
            nflt[i]   = int'(ir_xx_wdata[37:36]);
            nchain[i] = ir_xx_wdata[40];
            ncnt[i]   = int'(ir_xx_wdata[CNT_W-1:0]);
            nfs[i]    = 1'b0;
            if (nmode[i] < 1 || nmode[i] > 5) nph[i] = P_OFF;
            else if (ncnt[i] == 0)            nph[i] = P_ARM;
            else                              nph[i] = P_CNT;
         end else if (m_ph[i] == P_CNT) begin
            if (q && !spl && m_cnt[i] > 0) begin
               ncnt[i] = m_cnt[i] - 1;
               if (ncnt[i] == 0) nph[i] = P_ARM;
            end
         end else if (m_ph[i] == P_ARM) begin
            if (q && !spl) nph[i] = P_FIRE;
            else if (q && spl && is_data_mode(m_mode[i])) nph[i] = P_PEND;
         end else if (m_ph[i] == P_PEND) begin
            if (rtu_yy_xx_flush || rtu_yy_xx_dbgon) nph[i] = P_ARM;
            else if (rtu_had_inst_bkpt_inst_vld && !spl) nph[i] = P_FIRE;
         end else if (m_ph[i] == P_FIRE) begin
            if (ctrl_bkpt_ack || rtu_yy_xx_flush) begin
               nph[i] = P_ARM;
               ncnt[i] = 0;
            end
         end
      end
      o = '0;
      for (int i = 0; i < CHN; i++) begin
         m_ph[i] = nph[i]; m_mode[i] = nmode[i]; m_flt[i] = nflt[i]; m_cnt[i] = ncnt[i];
         m_chain[i] = nchain[i]; m_fs[i] = nfs[i];
         o.mbc[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
         if (m_ph[i] == P_FIRE) begin
            o.chn[i] = 1'b1;
            if (is_data_mode(m_mode[i])) o.dreq = 1'b1;
            else                         o.ireq = 1'b1;
         end
      end
      for (int i = CHN - 1; i >= 0; i--)
         if (o.chn[i]) o.id = ID_W'(i);
      return o;
   endfunction

   // Scoreboard monitor: one expectation per clocked step, checked after the edge.
   always @(posedge cpuclk) begin
      #2;
      cyc++;
      if (exp_q.size() > 0) begin
         mon_exp = exp_q.pop_front();
         mon_act = {bkpt_ctrl_inst_req, bkpt_ctrl_data_req, bkpt_ctrl_req_chn,
                    bkpt_ctrl_chn_id, bkpt_regs_mbc};
         total++;
         if (mon_act !== mon_exp) begin
            bad++;
            $display("FAIL scoreboard cyc=%0d actual=%h required=%h", cyc, mon_act, mon_exp);
         end
      end
   end

   task automatic chk(string name, logic [63:0] act, logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic idle();
      ctrl_bkpt_en = 1'b1; cp0_yy_priv_mode = 2'b00; rtu_had_inst_bkpt_inst_vld = 1'b0;
      rtu_had_inst_hit = '0; rtu_had_data_hit = '0; rtu_had_bkpt_data_st = 1'b0;
      rtu_had_xx_mbkpt_chgflow = 1'b0; rtu_had_xx_split_inst = 1'b0;
      rtu_yy_xx_retire0_normal = 1'b1; rtu_yy_xx_dbgon = 1'b0; rtu_yy_xx_flush = 1'b0;
      x_sm_xx_update_dr_en = 1'b0; ir_xx_mbc_reg_sel = '0; ir_xx_wdata = '0;
      ctrl_bkpt_ack = 1'b0;
   endtask

   // Called on a falling edge with inputs set; returns on the next falling edge.
   task automatic step();
      exp_q.push_back(model_next());
      @(negedge cpuclk);
   endtask

   task automatic wr(int ch, int mode, int flt, bit chain, int cnt);
      logic [63:0] w;
      w = '0;
      w[CNT_W-1:0] = cnt[CNT_W-1:0];
      w[34:32] = mode[2:0];
      w[37:36] = flt[1:0];
      w[40] = chain;
      x_sm_xx_update_dr_en = 1'b1;
      ir_xx_mbc_reg_sel = CHN'(1) << ch;
      ir_xx_wdata = w;
      step(); idle();
   endtask

   task automatic hit(logic [CHN-1:0] im, logic [CHN-1:0] dm, bit st, bit split, bit dbg);
      rtu_had_inst_bkpt_inst_vld = 1'b1;
      rtu_had_inst_hit = im; rtu_had_data_hit = dm; rtu_had_bkpt_data_st = st;
      rtu_had_xx_split_inst = split; rtu_yy_xx_dbgon = dbg;
      step(); idle();
   endtask

   task automatic ack();
      ctrl_bkpt_ack = 1'b1;
      step(); idle();
   endtask

   task automatic do_reset(string tag);
      #1 cpurst = 1'b1;
      #1;
      chk({tag, "_inst_req"}, bkpt_ctrl_inst_req, 0);
      chk({tag, "_data_req"}, bkpt_ctrl_data_req, 0);
      chk({tag, "_req_chn"}, bkpt_ctrl_req_chn, 0);
      chk({tag, "_chn_id"}, bkpt_ctrl_chn_id, 0);
      chk({tag, "_mbc"}, bkpt_regs_mbc, 0);
      model_reset();
      @(negedge cpuclk);
      @(negedge cpuclk);
      cpurst = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] w;
      idle();
      model_reset();
      repeat (2) @(negedge cpuclk);
      do_reset("reset");

      // Counted instruction breakpoint on ch0.
      wr(0, 1, 0, 0, 2);
      chk("cnt_mbc2", bkpt_regs_mbc[7:0], 2);
      hit(4'b0001, 4'b0000, 0, 0, 0);
      chk("cnt_mbc1", bkpt_regs_mbc[7:0], 1);
      hit(4'b0001, 4'b0000, 0, 0, 0);
      chk("cnt_mbc0", bkpt_regs_mbc[7:0], 0);
      chk("cnt_noreq", bkpt_ctrl_inst_req, 0);
      hit(4'b0001, 4'b0000, 0, 0, 0);
      chk("cnt_inst_req", bkpt_ctrl_inst_req, 1);
      chk("cnt_req_chn", bkpt_ctrl_req_chn, 4'b0001);
      ack();
      chk("cnt_ack", bkpt_ctrl_inst_req, 0);

      // Store-only data breakpoint on ch1.
      wr(1, 4, 0, 0, 0);
      hit(4'b0000, 4'b0010, 0, 0, 0);
      chk("st_load_ignored", bkpt_ctrl_data_req, 0);
      hit(4'b0000, 4'b0010, 1, 0, 0);
      chk("st_data_req", bkpt_ctrl_data_req, 1);
      chk("st_req_chn", bkpt_ctrl_req_chn, 4'b0010);
      chk("st_chn_id", bkpt_ctrl_chn_id, 1);
      ack();

      // Split data access on ch2: pend, fire on last piece, flush from pend.
      wr(2, 3, 0, 0, 0);
      hit(4'b0000, 4'b0100, 0, 1, 0);
      chk("pend_noreq", bkpt_ctrl_data_req, 0);
      hit(4'b0000, 4'b0000, 0, 0, 0);
      chk("pend_fire", bkpt_ctrl_data_req, 1);
      chk("pend_req_chn", bkpt_ctrl_req_chn, 4'b0100);
      ack();
      hit(4'b0000, 4'b0100, 0, 1, 0);
      rtu_yy_xx_flush = 1'b1;
      step(); idle();
      hit(4'b0000, 4'b0000, 0, 0, 0);
      chk("pend_flush_noreq", bkpt_ctrl_data_req, 0);
      hit(4'b0000, 4'b0100, 1, 0, 0);
      chk("pend_rearmed", bkpt_ctrl_data_req, 1);
      ack();

      // Simultaneous fires on ch0 and ch3.
      wr(3, 1, 0, 0, 0);
      hit(4'b1001, 4'b0000, 0, 0, 0);
      chk("multi_req_chn", bkpt_ctrl_req_chn, 4'b1001);
      chk("multi_chn_id", bkpt_ctrl_chn_id, 0);
      ack();
      chk("multi_ack", bkpt_ctrl_req_chn, 0);

`ifdef HAD_MBKPT_CHAIN_EN
      do_reset("chain_rst");
      wr(0, 1, 0, 0, 0);
      wr(1, 1, 0, 1, 0);
      hit(4'b0010, 4'b0000, 0, 0, 0);
      chk("chain_blocked", bkpt_ctrl_req_chn, 4'b0000);
      hit(4'b0001, 4'b0000, 0, 0, 0);
      chk("chain_ch0", bkpt_ctrl_req_chn, 4'b0001);
      ack();
      hit(4'b0010, 4'b0000, 0, 0, 0);
      chk("chain_ch1", bkpt_ctrl_req_chn, 4'b0010);
      ack();
`else
      wr(1, 1, 0, 1, 0);
      hit(4'b0010, 4'b0000, 0, 0, 0);
      chk("nochain_ch1", bkpt_ctrl_req_chn, 4'b0010);
      ack();
`endif

      // Privilege filter: user-only channel.
      wr(2, 1, 1, 0, 0);
      cp0_yy_priv_mode = 2'b11;
      hit(4'b0100, 4'b0000, 0, 0, 0);
      chk("flt_priv_blocked", bkpt_ctrl_inst_req, 0);
      hit(4'b0100, 4'b0000, 0, 0, 0);
      chk("flt_user_fire", bkpt_ctrl_req_chn, 4'b0100);
      ack();

      // Debug mode suppresses decrement; reset while fired.
      wr(3, 1, 0, 0, 3);
      hit(4'b1000, 4'b0000, 0, 0, 1);
      chk("dbgon_nodec", bkpt_regs_mbc[31:24], 3);
      hit(4'b0001, 4'b0000, 0, 0, 0);
      chk("pre_rst_fired", bkpt_ctrl_inst_req, 1);
      do_reset("fired_rst");

      // Random traffic.
      for (int n = 0; n < 2000; n++) begin
         ctrl_bkpt_en               = ($urandom_range(0, 7) != 0);
         cp0_yy_priv_mode           = 2'($urandom_range(0, 3));
         rtu_had_inst_bkpt_inst_vld = ($urandom_range(0, 3) != 0);
         rtu_had_inst_hit           = CHN'($urandom);
         rtu_had_data_hit           = CHN'($urandom);
         rtu_had_bkpt_data_st       = 1'($urandom);
         rtu_had_xx_mbkpt_chgflow   = 1'($urandom);
         rtu_had_xx_split_inst      = ($urandom_range(0, 3) == 0);
         rtu_yy_xx_retire0_normal   = ($urandom_range(0, 7) != 0);
         rtu_yy_xx_dbgon            = ($urandom_range(0, 9) == 0);
         rtu_yy_xx_flush            = ($urandom_range(0, 15) == 0);
         ctrl_bkpt_ack              = ($urandom_range(0, 3) == 0);
         x_sm_xx_update_dr_en       = ($urandom_range(0, 9) == 0);
         ir_xx_mbc_reg_sel          = CHN'(1) << $urandom_range(0, CHN - 1);
         w = {$urandom, $urandom};
         w[CNT_W-1:0] = CNT_W'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 0) w[34:32] = 3'($urandom_range(1, 5));
         ir_xx_wdata = w;
         step();
      end
      idle();
      repeat (2) @(negedge cpuclk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ct_had_mbkpt_chan.md
CT_HAD_MBKPT_CHAN -- requirements
Module: ct_had_mbkpt_chan

Interface
REQ-001 SHALL have parameter CHN, default 4, meaning number of breakpoint channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 8, meaning per-channel match-counter width (1..16).
REQ-003 SHALL have port cpuclk, input, 1, the single clock; all state is on its rising edge.
REQ-004 SHALL have port cpurst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port ctrl_bkpt_en, input, 1, global enable for decrement and fire.
REQ-006 SHALL have port cp0_yy_priv_mode, input, 2, current privilege; 2'b00 is user.
REQ-007 SHALL have port rtu_had_inst_bkpt_inst_vld, input, 1, the retiring instruction is valid; it qualifies every hit.
REQ-008 SHALL have ports rtu_had_inst_hit and rtu_had_data_hit, input, CHN each, per-channel address-match hits.
REQ-009 SHALL have ports rtu_had_bkpt_data_st, rtu_had_xx_mbkpt_chgflow, rtu_had_xx_split_inst, rtu_yy_xx_retire0_normal, rtu_yy_xx_dbgon and rtu_yy_xx_flush, input, 1 each, with their existing RTU meanings.
REQ-010 SHALL have ports x_sm_xx_update_dr_en (input, 1), ir_xx_mbc_reg_sel (input, CHN, one-hot) and ir_xx_wdata (input, 64), forming the channel configuration write.
REQ-011 SHALL have port ctrl_bkpt_ack, input, 1, controller acceptance of the pending request.
REQ-012 SHALL have ports bkpt_ctrl_inst_req and bkpt_ctrl_data_req, output, 1 each, registered request level per type.
REQ-013 SHALL have ports bkpt_ctrl_req_chn (output, CHN, per-channel fired flags) and bkpt_ctrl_chn_id (output, $clog2(CHN), lowest fired index; minimum width 1).
REQ-014 SHALL have port bkpt_regs_mbc, output, CHN*CNT_W, packed live counters with channel 0 in the LSBs.

Function
REQ-015 SHALL decode the write fields as: wdata[CNT_W-1:0] count; [34:32] mode (0 off, 1 inst, 2 chgflow inst, 3 data any, 4 store, 5 load, others off); [37:36] privilege filter (0 any, 1 user only, 2 priv only, 3 never); [40] chain.
REQ-016 SHALL register the mode/privilege-filter qualification one cycle before use.
REQ-017 SHALL define per-channel qualified hit Q as the mode-selected hit AND the filter pass AND inst_vld AND retire0_normal AND ctrl_bkpt_en AND NOT dbgon.
REQ-018 SHALL give each channel the states OFF, COUNT, ARMED, PEND and FIRED.
REQ-019 SHALL on a configuration write enter OFF if mode is off, else ARMED if count==0, else COUNT; a write SHALL override any same-cycle event for that channel.
REQ-020 In COUNT, Q with split_inst=0 SHALL decrement the counter; reaching 0 SHALL move the channel to ARMED; the counter SHALL never wrap below 0.
REQ-021 In ARMED, Q with split_inst=0 SHALL enter FIRED next cycle; a data Q with split_inst=1 SHALL enter PEND; an inst Q with split_inst=1 SHALL be ignored.
REQ-022 PEND SHALL enter FIRED on the next inst_vld with split_inst=0, and SHALL return to ARMED on flush or dbgon.
REQ-023 FIRED SHALL hold until ctrl_bkpt_ack or flush, then return to ARMED with the counter at 0.
REQ-024 Simultaneous fires SHALL all set their bkpt_ctrl_req_chn bits; chn_id SHALL report the lowest set bit.
REQ-025 inst_req SHALL be the OR of fired inst/chgflow channels, and data_req SHALL be the OR of fired data channels.

Reset
REQ-026 On cpurst all channels SHALL be OFF, counters 0, and all outputs 0, including mid-PEND or mid-FIRED.

Configuration
REQ-027 With HAD_MBKPT_CHAIN_EN defined, a channel i>0 with chain=1 SHALL ignore Q until channel i-1 has fired since i-1 was last written.
REQ-028 Without HAD_MBKPT_CHAIN_EN, chain bit 40 SHALL be ignored and all channels SHALL be independent.

Structure
REQ-029 A shared package SHALL hold the mode and filter encodings, the state enum and the wdata field offsets.
REQ-030 One sub-module, ct_had_mbkpt_slot, SHALL implement a single channel; the top SHALL instantiate CHN slots and the priority encoder.

Verification
REQ-031 Ch0 mode=inst, count=2: three inst hits -> mbc 2->1->0, inst_req=1 one cycle after the 3rd hit.
REQ-032 Ch1 mode=store, count=0: a load hit produces no request; a store hit -> data_req=1 and req_chn=4'b0010.
REQ-033 Ch2 mode=data, count=0: split hit -> PEND with no request; final piece -> data_req; a flush while in PEND returns to ARMED.
REQ-034 Ch0 and ch3 fire in the same cycle -> req_chn=4'b1001 and chn_id=0; ack clears both.
REQ-035 With CHAIN_EN, ch1 chain=1: a ch1 hit before ch0 fires is ignored; after ch0 fires, a ch1 hit -> fire.
REQ-036 Assert cpurst while FIRED -> all outputs 0 immediately; a hit with dbgon=1 -> no decrement.
